// File: rtl/csa_ctrl_pkg.sv
// Shared types and default parameters for the carry-save accumulator controller.
// The FSM state encodings are fixed here so every file decodes them the same way.
package csa_ctrl_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_ACC_W   = 8;
    localparam int DEF_MAX_OPS = 8;
    localparam int OPS_W       = 8;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/csa_accumulator_ctrl_if.sv
// Operand-in / result-out handshake bundle for csa_accumulator_ctrl.
// The master side offers operands and consumes results; the slave side is the accumulator.
interface csa_accumulator_ctrl_if #(
    parameter int WIDTH = csa_ctrl_pkg::DEF_WIDTH,
    parameter int ACC_W = csa_ctrl_pkg::DEF_ACC_W
);

    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH-1:0]               in_data;
    logic                           in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [ACC_W-1:0]               out_sum;
    logic [csa_ctrl_pkg::OPS_W-1:0] out_ops;
    logic                           out_trunc;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ops, out_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ops, out_trunc
    );

endinterface

// File: rtl/csa_row.sv
// One row of 3:2 compressors: bitwise full adders with the carry left unshifted.
module csa_row #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator_ctrl.sv
// Frame accumulator: operands are folded into a carry-save pair one per cycle,
// then resolved by a single carry-propagate add and held until the result is taken.
module csa_accumulator_ctrl
    import csa_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MAX_OPS = DEF_MAX_OPS
) (
    input  logic                  clk,
    input  logic                  rst,
    csa_accumulator_ctrl_if.slave bus
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d, c_q, c_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [OPS_W-1:0]   cnt_q, cnt_d, out_ops_q, out_ops_d;
    logic               out_trunc_q, out_trunc_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   x, row_sum, row_carry;
    logic [OPS_W-1:0]   cnt_inc;
    logic               accept, handshake;

    assign x         = ACC_W'(bus.in_data);
    assign accept    = bus.in_valid && in_ready_q;
    assign handshake = out_valid_q && bus.out_ready;
    assign cnt_inc   = cnt_q + OPS_W'(1);

    csa_row #(.W(ACC_W)) u_row (
        .a     (s_q),
        .b     (c_q),
        .c     (x),
        .sum   (row_sum),
        .carry (row_carry)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_ops_d   = out_ops_q;
        out_trunc_d = out_trunc_q;

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    s_d   = row_sum;
                    c_d   = row_carry << 1;
                    cnt_d = cnt_inc;
                    if (bus.in_last || cnt_inc == OPS_W'(MAX_OPS)) begin
                        state_d     = RESOLVE;
                        out_trunc_d = !bus.in_last;
                    end
                end
            end
            RESOLVE: begin
                out_sum_d = s_q + c_q;
                out_ops_d = cnt_q;
                state_d   = DONE;
            end
            DONE: begin
                if (handshake) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase

        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_q == DONE) && !handshake;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_ops_q   <= '0;
            out_trunc_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_ops_q   <= out_ops_d;
            out_trunc_q <= out_trunc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ops   = out_ops_q;
    assign bus.out_trunc = out_trunc_q;

endmodule

// File: tb/tb_csa_accumulator_ctrl.sv
// Self-checking bench for csa_accumulator_ctrl: directed frame table, multi-cycle
// corner sequences, and random frames checked against a plain-arithmetic frame model.
module tb_csa_accumulator_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_accumulator_ctrl_if #(.WIDTH(4), .ACC_W(8)) bus  ();
    csa_accumulator_ctrl_if #(.WIDTH(4), .ACC_W(6)) bus6 ();

    csa_accumulator_ctrl #(.WIDTH(4), .ACC_W(8), .MAX_OPS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    csa_accumulator_ctrl #(.WIDTH(4), .ACC_W(6), .MAX_OPS(8)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          n;
        logic [31:0] data;   // beat j is nibble j
        bit          last;
        int          sum;
        int          ops;
        bit          trunc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    function automatic logic ov(input bit sel);
        return sel ? bus6.out_valid : bus.out_valid;
    endfunction

    function automatic logic ir(input bit sel);
        return sel ? bus6.in_ready : bus.in_ready;
    endfunction

    function automatic logic [7:0] osum(input bit sel);
        return sel ? 8'(bus6.out_sum) : bus.out_sum;
    endfunction

    function automatic logic [7:0] oops(input bit sel);
        return sel ? bus6.out_ops : bus.out_ops;
    endfunction

    function automatic logic otr(input bit sel);
        return sel ? bus6.out_trunc : bus.out_trunc;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with in_valid low.
    task automatic beat(input bit sel, input logic [3:0] d, input bit last);
        int k = 0;
        if (sel) begin
            bus6.in_valid = 1'b1; bus6.in_data = d; bus6.in_last = last;
        end else begin
            bus.in_valid = 1'b1;  bus.in_data = d;  bus.in_last = last;
        end
        while (!ir(sel) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) timeout("beat_accept");
        @(posedge clk);
        @(negedge clk);
        if (sel) begin
            bus6.in_valid = 1'b0; bus6.in_data = 4'($urandom); bus6.in_last = 1'($urandom);
        end else begin
            bus.in_valid = 1'b0;  bus.in_data = 4'($urandom);  bus.in_last = 1'($urandom);
        end
    endtask

    // Waits for out_valid, holds out_ready low for 'hold' cycles checking stability, then accepts.
    task automatic get_result(input bit sel, input int hold,
                              output logic [7:0] sum, output logic [7:0] ops,
                              output logic trunc, output int lat);
        lat = 0;
        sum = '0; ops = '0; trunc = 1'b0;
        while (!ov(sel) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) begin
            timeout("out_valid_wait");
            return;
        end
        sum = osum(sel); ops = oops(sel); trunc = otr(sel);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(ov(sel)), 32'd1);
            check("hold_out_sum",   32'(osum(sel)), 32'(sum));
            check("hold_out_ops",   32'(oops(sel)), 32'(ops));
            check("hold_in_ready",  32'(ir(sel)), 32'd0);
        end
        if (sel) bus6.out_ready = 1'b1; else bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (sel) bus6.out_ready = 1'b0; else bus.out_ready = 1'b0;
        check("valid_drop_after_take", 32'(ov(sel)), 32'd0);
        check("ready_after_take",      32'(ir(sel)), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sum, ops;
        logic       trunc;
        int         lat;
        int         k;

        vecs[0] = '{3, 32'h0000_0753, 1'b1,  15, 3, 1'b0};
        vecs[1] = '{1, 32'h0000_000F, 1'b1,  15, 1, 1'b0};
        vecs[2] = '{8, 32'h8765_4321, 1'b1,  36, 8, 1'b0};
        vecs[3] = '{2, 32'h0000_0000, 1'b1,   0, 2, 1'b0};
        vecs[4] = '{7, 32'h0FFF_FFFF, 1'b1, 105, 7, 1'b0};
        vecs[5] = '{8, 32'hFFFF_FFFF, 1'b0, 120, 8, 1'b1};

        {bus.in_valid, bus.in_data, bus.in_last, bus.out_ready}     = '0;
        {bus6.in_valid, bus6.in_data, bus6.in_last, bus6.out_ready} = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum",   32'(bus.out_sum), 32'd0);
        check("rst_out_ops",   32'(bus.out_ops), 32'd0);
        check("rst_out_trunc", 32'(bus.out_trunc), 32'd0);
        rst = 1'b0;
        #1 check("in_ready_before_first_edge", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("in_ready_after_release", 32'(bus.in_ready), 32'd1);

        // Directed frame table
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                beat(1'b0, vecs[i].data[4*j +: 4], (j == vecs[i].n - 1) ? vecs[i].last : 1'b0);
            get_result(1'b0, 0, sum, ops, trunc, lat);
            check($sformatf("vec%0d_sum", i),     32'(sum),   32'(vecs[i].sum));
            check($sformatf("vec%0d_ops", i),     32'(ops),   32'(vecs[i].ops));
            check($sformatf("vec%0d_trunc", i),   32'(trunc), 32'(vecs[i].trunc));
            check($sformatf("vec%0d_latency", i), 32'(lat),   32'd2);
        end

        // MAX_OPS truncation: a ninth beat stalls through RESOLVE and a 5-cycle DONE hold
        for (int j = 0; j < 8; j++) beat(1'b0, 4'hF, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = 4'h1; bus.in_last = 1'b1;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        check("trunc_latency", 32'(k), 32'd2);
        check("trunc_sum",   32'(bus.out_sum), 32'd120);
        check("trunc_ops",   32'(bus.out_ops), 32'd8);
        check("trunc_flag",  32'(bus.out_trunc), 32'd1);
        get_result(1'b0, 5, sum, ops, trunc, lat);
        check("trunc_taken_sum", 32'(sum), 32'd120);
        beat(1'b0, 4'h1, 1'b1);
        get_result(1'b0, 0, sum, ops, trunc, lat);
        check("ninth_sum",   32'(sum), 32'd1);
        check("ninth_ops",   32'(ops), 32'd1);
        check("ninth_trunc", 32'(trunc), 32'd0);

        // Reset mid-frame discards the partial frame
        beat(1'b0, 4'h1, 1'b0);
        beat(1'b0, 4'h2, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready), 32'd0);
        check("midrst_out_sum",   32'(bus.out_sum), 32'd0);
        check("midrst_out_ops",   32'(bus.out_ops), 32'd0);
        check("midrst_out_trunc", 32'(bus.out_trunc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midrst_no_valid", 32'(bus.out_valid), 32'd0);
        end
        beat(1'b0, 4'h1, 1'b0);
        beat(1'b0, 4'h2, 1'b1);
        get_result(1'b0, 0, sum, ops, trunc, lat);
        check("post_rst_sum", 32'(sum), 32'd3);
        check("post_rst_ops", 32'(ops), 32'd2);

        // Reset while a result is pending in DONE
        beat(1'b0, 4'h9, 1'b1);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) timeout("done_rst_wait");
        #2 rst = 1'b1;
        #1;
        check("donerst_out_valid", 32'(bus.out_valid), 32'd0);
        check("donerst_out_sum",   32'(bus.out_sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("donerst_no_valid", 32'(bus.out_valid), 32'd0);
        end

        // ACC_W=6 wrap: 5 x 15 = 75 -> 11
        for (int j = 0; j < 5; j++) beat(1'b1, 4'hF, j == 4);
        get_result(1'b1, 0, sum, ops, trunc, lat);
        check("w6_sum",     32'(sum), 32'd11);
        check("w6_ops",     32'(ops), 32'd5);
        check("w6_trunc",   32'(trunc), 32'd0);
        check("w6_latency", 32'(lat), 32'd2);

        // Random frames against the frame model
        for (int f = 0; f < 40; f++) begin
            bit          sel;
            int          n;
            bit          last;
            int          acc;
            int          modv;
            logic [3:0]  d;
            sel  = 1'($urandom);
            n    = int'($urandom_range(1, 8));
            last = (n < 8) ? 1'b1 : 1'($urandom);
            modv = sel ? 64 : 256;
            acc  = 0;
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                d = 4'($urandom);
                acc += int'(d);
                beat(sel, d, (j == n - 1) ? last : 1'b0);
            end
            get_result(sel, int'($urandom_range(0, 3)), sum, ops, trunc, lat);
            check($sformatf("rnd%0d_sum", f),   32'(sum),   32'(acc % modv));
            check($sformatf("rnd%0d_ops", f),   32'(ops),   32'(n));
            check($sformatf("rnd%0d_trunc", f), 32'(trunc), 32'(n == 8 && !last));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csa_accumulator_ctrl.md
CSA_ACCUMULATOR_CTRL -- requirements
Module: csa_accumulator_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 8, accumulator/result width in bits (ACC_W >= WIDTH).
REQ-003 SHALL have parameter MAX_OPS, default 8, maximum operands per frame (2..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operand beat offered.
REQ-007 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data  input  WIDTH  operand, unsigned.
REQ-009 SHALL have port in_last  input  1  final operand of frame.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 SHALL have port out_sum  output  ACC_W  frame sum modulo 2^ACC_W.
REQ-013 SHALL have port out_ops  output  8  number of operands in frame.
REQ-014 SHALL have port out_trunc  output  1  frame closed by MAX_OPS limit, not in_last.

Function
REQ-015 SHALL implement FSM states ACCUM, RESOLVE, DONE.
REQ-016 ACCUM: in_ready=1, out_valid=0; each accepted beat updates carry-save pair: s' = s ^ c ^ x; c' = maj(s,c,x) << 1, truncated to ACC_W; x = in_data zero-extended to ACC_W; op count +1.
REQ-017 Beat with in_last=1, or the beat taking op count to MAX_OPS, SHALL transition ACCUM -> RESOLVE; out_trunc latched = 1 only if in_last=0 on that beat.
REQ-018 RESOLVE: in_ready=0; single cycle; out_sum <= (s + c) mod 2^ACC_W, out_ops <= count; -> DONE.
REQ-019 DONE: out_valid=1, in_ready=0; out_sum/out_ops/out_trunc held stable until out_ready=1.
REQ-020 On DONE handshake SHALL clear s, c, count to 0 and go to ACCUM next cycle; out_valid deasserts that cycle.
REQ-021 Latency: last beat accepted at edge N -> out_valid high after edge N+2.
REQ-022 No beat SHALL be accepted in RESOLVE or DONE; in_valid there is ignored (sender holds it).
REQ-023 out_sum SHALL wrap modulo 2^ACC_W; no overflow flag.
REQ-024 in_data/in_last SHALL be ignored when in_valid=0.
REQ-025 Throughput: one beat per cycle in ACCUM; minimum frame period = ops + 2 cycles + out handshake.

Reset
REQ-026 rst=1 SHALL asynchronously force state ACCUM, s=c=0, count=0, out_sum=0, out_ops=0, out_trunc=0, out_valid=0.
REQ-027 in_ready SHALL be 1 one cycle after rst deasserts (ACCUM), 0 while rst=1.
REQ-028 Reset mid-frame or in DONE SHALL discard the partial frame/result without emitting out_valid.

Structure
REQ-029 Shared package/include csa_ctrl_pkg SHALL hold state encodings (ACCUM=2'd0, RESOLVE=2'd1, DONE=2'd2) and default WIDTH/ACC_W/MAX_OPS constants.
REQ-030 The 3:2 compression SHALL be one sub-module csa_row (parameter W; inputs a,b,c; outputs sum, carry unshifted), instantiated once at ACC_W.
REQ-031 Final add SHALL be a single carry-propagate adder in the RESOLVE path; no other adders in the datapath.

Verification (WIDTH=4, ACC_W=8, MAX_OPS=8 unless stated)
REQ-032 Beats 3,5,7(last), out_ready=1 -> out_sum=15, out_ops=3, out_trunc=0, out_valid 2 cycles after last beat.
REQ-033 Single beat 4'hF with in_last -> out_sum=15, out_ops=1, out_trunc=0.
REQ-034 Eight beats of 15, in_last=0 -> out_sum=120, out_ops=8, out_trunc=1; 9th beat stalls (in_ready=0) until DONE handshake.
REQ-035 out_ready=0 for 5 cycles in DONE -> out_valid, out_sum, out_ops stable, in_ready=0; accept on 6th.
REQ-036 rst pulse after two beats (1,2) -> all outputs 0, no out_valid; then frame 1,2(last) -> out_sum=3, out_ops=2.
REQ-037 ACC_W=6: five beats of 15, last on 5th -> out_sum=11 (75 mod 64), out_ops=5.
